// File: rtl/simd_lane_writeback.sv
// ============================================================================
// Module   : simd_lane_writeback
// Purpose  : Per-lane register-file writeback sequencer. It merges ALU results
//            and load responses into one register write per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module simd_lane_writeback #(
  parameter int DATA_REG_ADDR_WIDTH = 7,
  parameter int DATA_WIDTH          = 64,
  parameter int NUM_GP_REGS         = 28,
  parameter int MEM_FIFO_DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [2:0]                     simd_state,
  input  logic                           alu_valid,
  output logic                           alu_ready,
  input  logic [DATA_REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]          alu_data,
  input  logic                           mem_valid,
  output logic                           mem_ready,
  input  logic [DATA_REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]          mem_data,
  output logic                           reg_write,
  output logic [DATA_REG_ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]          write_data,
  output logic                           wb_done,
  output logic                           illegal_rd
);

  localparam int PTR_W = (MEM_FIFO_DEPTH > 1) ? $clog2(MEM_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(MEM_FIFO_DEPTH + 1);
  localparam logic [2:0]                     c_st_update = 3'b110;
  localparam logic [CNT_W-1:0]               c_fifo_full = CNT_W'(MEM_FIFO_DEPTH);
  localparam logic [DATA_REG_ADDR_WIDTH-1:0] c_num_gp    = DATA_REG_ADDR_WIDTH'(NUM_GP_REGS);

  // ALU hold register
  logic                           hold_valid_q, hold_valid_d;
  logic [DATA_REG_ADDR_WIDTH-1:0] hold_rd_q, hold_rd_d;
  logic [DATA_WIDTH-1:0]          hold_data_q, hold_data_d;

  // Load-response FIFO
  logic [DATA_REG_ADDR_WIDTH-1:0] fifo_rd_q   [MEM_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]          fifo_data_q [MEM_FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]               count_q, count_d;

  // Presentation register
  logic                           pres_valid_q, pres_valid_d;
  logic [DATA_REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;

  logic illegal_q, wb_done_q, armed_q;

  logic w_alu_fire, w_mem_fire, w_alu_legal, w_mem_legal;
  logic w_commit, w_pres_load, w_take_fifo, w_push, w_all_empty;

  assign alu_ready  = enable && !hold_valid_q;
  assign mem_ready  = enable && (count_q < c_fifo_full);
  assign reg_write  = pres_valid_q && enable;
  assign rd         = rd_q;
  assign write_data = wdata_q;
  assign wb_done    = wb_done_q && enable;
  assign illegal_rd = illegal_q;

  assign w_alu_fire  = alu_valid && alu_ready;
  assign w_mem_fire  = mem_valid && mem_ready;
  assign w_alu_legal = alu_rd < c_num_gp;
  assign w_mem_legal = mem_rd < c_num_gp;
  assign w_push      = w_mem_fire && w_mem_legal;

  assign w_commit    = reg_write && (simd_state == c_st_update);
  assign w_pres_load = enable && (!pres_valid_q || w_commit);
  // The FIFO only feeds presentation when the ALU hold has nothing to offer.
  assign w_take_fifo = w_pres_load && !hold_valid_q && (count_q != '0);

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;
    pres_valid_d = pres_valid_q;
    rd_d         = rd_q;
    wdata_d      = wdata_q;

    if (w_pres_load) begin
      if (hold_valid_q) begin
        pres_valid_d = 1'b1;
        rd_d         = hold_rd_q;
        wdata_d      = hold_data_q;
        hold_valid_d = 1'b0;
      end else if (w_take_fifo) begin
        pres_valid_d = 1'b1;
        rd_d         = fifo_rd_q[rd_ptr_q];
        wdata_d      = fifo_data_q[rd_ptr_q];
      end else begin
        pres_valid_d = 1'b0;
      end
    end

    if (w_alu_fire && w_alu_legal) begin
      hold_valid_d = 1'b1;
      hold_rd_d    = alu_rd;
      hold_data_d  = alu_data;
    end

    count_d = count_q + CNT_W'(w_push) - CNT_W'(w_take_fifo);
  end

  assign w_all_empty = !hold_valid_d && !pres_valid_d && (count_d == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pres_valid_q <= 1'b0;
      rd_q         <= '0;
      wdata_q      <= '0;
      illegal_q    <= 1'b0;
      wb_done_q    <= 1'b0;
      armed_q      <= 1'b1;
    end else if (enable) begin
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      pres_valid_q <= pres_valid_d;
      rd_q         <= rd_d;
      wdata_q      <= wdata_d;
      count_q      <= count_d;
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (w_take_fifo) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if ((w_alu_fire && !w_alu_legal) || (w_mem_fire && !w_mem_legal)) begin
        illegal_q <= 1'b1;
      end
      // One pulse per contiguous UPDATE phase; leaving UPDATE re-arms it.
      if (simd_state == c_st_update) begin
        if (armed_q && w_all_empty) begin
          wb_done_q <= 1'b1;
          armed_q   <= 1'b0;
        end else begin
          wb_done_q <= 1'b0;
        end
      end else begin
        wb_done_q <= 1'b0;
        armed_q   <= 1'b1;
      end
    end else begin
      wb_done_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      fifo_rd_q[wr_ptr_q]   <= mem_rd;
      fifo_data_q[wr_ptr_q] <= mem_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_simd_lane_writeback.sv
// ============================================================================
// Module   : tb_simd_lane_writeback
// Purpose  : Scoreboard bench for simd_lane_writeback with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_simd_lane_writeback;

  localparam logic [2:0] UPD  = 3'b110;
  localparam logic [2:0] EXEC = 3'b011;
  localparam logic [2:0] IDLE = 3'b000;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [2:0]  simd_state;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [6:0]  alu_rd, mem_rd, rd;
  logic [63:0] alu_data, mem_data, write_data;
  logic        reg_write, wb_done, illegal_rd;

  always #5 clk = ~clk;

  simd_lane_writeback dut (
    .clk(clk), .rst(rst), .enable(enable), .simd_state(simd_state),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .reg_write(reg_write), .rd(rd), .write_data(write_data),
    .wb_done(wb_done), .illegal_rd(illegal_rd)
  );

  typedef struct packed {
    logic [6:0]  rd;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  wb_cnt = 0;
  int  w0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Commits are judged at the falling edge before the edge that performs them.
  always @(negedge clk) begin
    if (!rst && reg_write && simd_state == UPD) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write", rd, write_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("commit_rd", 64'(rd), 64'(mon_e.rd));
        chk("commit_data", write_data, mon_e.data);
      end
    end
    if (!rst && wb_done) begin
      wb_cnt++;
      chk("wb_done_pending", 64'(exp_q.size()), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_send(input logic [6:0] a, input logic [63:0] d);
    logic acc;
    int   n;
    alu_valid = 1'b1; alu_rd = a; alu_data = d;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = alu_ready;
      tick();
      n++;
    end
    alu_valid = 1'b0;
    chk("alu_accept", 64'(acc), 64'd1);
  endtask

  task automatic mem_send(input logic [6:0] a, input logic [63:0] d);
    logic acc;
    int   n;
    mem_valid = 1'b1; mem_rd = a; mem_data = d;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = mem_ready;
      tick();
      n++;
    end
    mem_valid = 1'b0;
    chk("mem_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rearm();
    simd_state = IDLE;
    tick();
    simd_state = EXEC;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; simd_state = EXEC;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_write_data", write_data, 64'd0);
    chk("rst_wb_done", 64'(wb_done), 64'd0);
    chk("rst_illegal", 64'(illegal_rd), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);
    tick();

    // 1: single ALU write, two-cycle presentation latency
    alu_send(7'd5, 64'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_not_yet", 64'(reg_write), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_present", 64'(reg_write), 64'd1);
    chk("t1_rd", 64'(rd), 64'd5);
    chk("t1_data", write_data, 64'hDEAD_BEEF);
    tick();
    @(negedge clk);
    chk("t1_held", 64'(reg_write), 64'd1);
    exp_q.push_back('{rd: 7'd5, data: 64'hDEAD_BEEF});
    w0 = wb_cnt;
    tick();
    simd_state = UPD;
    repeat (4) tick();
    @(negedge clk);
    chk("t1_after_commit", 64'(reg_write), 64'd0);
    chk("t1_wb_pulses", 64'(wb_cnt - w0), 64'd1);
    tick();

    // 2: fill the FIFO; the first load sits in presentation, the rest fill the FIFO
    rearm();
    for (int i = 1; i <= 5; i++) begin
      mem_send(7'(i), 64'h1000 + 64'(i));
      exp_q.push_back('{rd: 7'(i), data: 64'h1000 + 64'(i)});
    end
    mem_valid = 1'b1; mem_rd = 7'd6; mem_data = 64'h1006;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_full", 64'(mem_ready), 64'd0);
      tick();
    end
    mem_valid = 1'b0;
    w0 = wb_cnt;
    simd_state = UPD;
    wait_drain(20);
    repeat (3) tick();
    chk("t2_wb_pulses", 64'(wb_cnt - w0), 64'd1);

    // 3: ALU hold takes priority over the FIFO head
    rearm();
    mem_send(7'd6, 64'h66);
    mem_send(7'd7, 64'h77);
    alu_send(7'd9, 64'h99);
    exp_q.push_back('{rd: 7'd6, data: 64'h66});
    exp_q.push_back('{rd: 7'd9, data: 64'h99});
    exp_q.push_back('{rd: 7'd7, data: 64'h77});
    w0 = wb_cnt;
    tick();
    simd_state = UPD;
    wait_drain(20);
    repeat (3) tick();
    chk("t3_wb_pulses", 64'(wb_cnt - w0), 64'd1);

    // 4: read-only destinations are accepted and dropped
    rearm();
    @(negedge clk);
    chk("t4_illegal_before", 64'(illegal_rd), 64'd0);
    tick();
    alu_send(7'd30, 64'h3030);
    mem_send(7'd28, 64'h2828);
    repeat (3) tick();
    @(negedge clk);
    chk("t4_illegal", 64'(illegal_rd), 64'd1);
    chk("t4_no_write", 64'(reg_write), 64'd0);
    chk("t4_alu_ready", 64'(alu_ready), 64'd1);
    w0 = wb_cnt;
    tick();
    simd_state = UPD;
    repeat (3) tick();
    @(negedge clk);
    chk("t4_wb_pulses", 64'(wb_cnt - w0), 64'd1);
    chk("t4_illegal_sticky", 64'(illegal_rd), 64'd1);
    tick();

    // 5: enable freeze mid-drain
    rearm();
    for (int i = 10; i <= 13; i++) begin
      mem_send(7'(i), 64'hA000 + 64'(i));
      exp_q.push_back('{rd: 7'(i), data: 64'hA000 + 64'(i)});
    end
    w0 = wb_cnt;
    simd_state = UPD;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_frozen_write", 64'(reg_write), 64'd0);
      chk("t5_frozen_alu_ready", 64'(alu_ready), 64'd0);
      chk("t5_frozen_mem_ready", 64'(mem_ready), 64'd0);
      chk("t5_frozen_wb_done", 64'(wb_done), 64'd0);
      tick();
    end
    chk("t5_pending", 64'(exp_q.size()), 64'd3);
    enable = 1'b1;
    wait_drain(20);
    repeat (3) tick();
    chk("t5_wb_pulses", 64'(wb_cnt - w0), 64'd1);

    // 6: reset during UPDATE with two writes still pending
    rearm();
    for (int i = 20; i <= 22; i++) begin
      mem_send(7'(i), 64'hB000 + 64'(i));
      exp_q.push_back('{rd: 7'(i), data: 64'hB000 + 64'(i)});
    end
    simd_state = UPD;
    tick();
    rst = 1'b1;
    exp_q.delete();
    w0 = wb_cnt;
    tick();
    rst = 1'b0;
    simd_state = IDLE;
    @(negedge clk);
    chk("t6_reg_write", 64'(reg_write), 64'd0);
    chk("t6_alu_ready", 64'(alu_ready), 64'd1);
    chk("t6_mem_ready", 64'(mem_ready), 64'd1);
    chk("t6_illegal", 64'(illegal_rd), 64'd0);
    chk("t6_rd", 64'(rd), 64'd0);
    chk("t6_write_data", write_data, 64'd0);
    tick();
    simd_state = UPD;
    repeat (3) tick();
    @(negedge clk);
    chk("t6_wb_pulses", 64'(wb_cnt - w0), 64'd1);
    chk("t6_no_write", 64'(reg_write), 64'd0);
    tick();

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
